spi_lcd_rx: RTL and testbench
=============================

Name: spi_lcd_rx

Overview:
- Receive-side decoder for the 4-wire SPI LCD link (SCLK, SDA, D/C, CS_n, RST_n) driven by the LCD transmitter.
- Oversamples the link on the system clock and reassembles bytes, MSB first.
- Interprets the ST7735-style command set: CASET 0x2A, RASET 0x2B, RAMWR 0x2C.
- Emits addressed RGB565 pixel writes, so a frame mirror or scoreboard can rebuild the 132x162 image exactly as the panel would.

Parameters:
- LCD_W, 132, panel columns; reset value of column end = LCD_W-1.
- LCD_H, 162, panel rows; reset value of row end = LCD_H-1.

Ports:
- clk  input  1  system clock; must be at least 4x the SCLK frequency.
- rst  input  1  synchronous, active-high reset.
- lcd_clk_in  input  1  SPI SCLK; asynchronous to clk; data sampled on its rising edge.
- lcd_data_in  input  1  SPI SDA, MSB first.
- lcd_dc_in  input  1  0 = command byte, 1 = data byte.
- lcd_cs_n_in  input  1  active-low chip select.
- lcd_rst_n_in  input  1  active-low panel reset.
- cmd_valid  output  1  one-cycle pulse; a command byte was received.
- cmd_byte  output  8  last command byte received.
- pix_valid  output  1  one-cycle pulse; a pixel write occurred.
- pix_x  output  8  column of the pixel write.
- pix_y  output  8  row of the pixel write.
- pix_data  output  16  RGB565 value; first byte received is [15:8].
- frame_done  output  1  one-cycle pulse, coincident with the pix_valid for pixel (xe, ye).

Behaviour:
- Input synchronisation:
  - All five link inputs pass through 2-flop synchronisers.
  - An SCLK rise is a synchronised 0->1 transition, qualified by synchronised CS_n = 0.
- Shifter:
  - An 8-bit shift register and 3-bit bit counter advance on each qualified rise.
  - On the 8th rise the byte and the synchronised D/C are latched and byte_stb pulses for one cycle.
  - CS_n high clears the bit counter and discards any partial byte.
  - Parser state and pixel-byte phase are kept across CS_n high.
- Internal reset:
  - rst, or synchronised RST_n low, has the same effect.
  - Parser returns to CMD.
  - xs = 0, xe = LCD_W-1, ys = 0, ye = LCD_H-1; pointer = (0, 0).
  - Bit counter = 0, byte phase = 0.
  - All outputs = 0.
  - Reset mid-byte or mid-pixel abandons that byte or pixel silently.
- Latency:
  - Outputs are registered.
  - cmd_valid or pix_valid asserts exactly 4 clk after the clk edge at which the 8th SCLK rising edge appears at the pins.
- Parser FSM states: CMD, CASET_P, RASET_P, RAMWR, SKIP.
- Any command byte (D/C = 0):
  - Pulses cmd_valid and updates cmd_byte, in every state.
  - Aborts the current state and clears the param counter and byte phase.
  - 0x2A -> CASET_P; 0x2B -> RASET_P.
  - 0x2C -> RAMWR, with pointer loaded to (xs, ys).
  - Any other value -> SKIP.
- CASET_P / RASET_P:
  - Data bytes are counted 0..3. Bytes 0 and 2 (high bytes) are ignored.
  - Byte 1 -> xs/ys; byte 3 -> xe/ye.
  - After byte 3 -> SKIP; further data bytes are ignored.
- RAMWR:
  - Data bytes pair into pixels: phase 0 holds the high byte, phase 1 completes the pixel.
  - On completion: pix_valid = 1, pix_x/pix_y = pointer, pix_data = {hi, lo}.
  - Pointer update:
    - If x == xe: x <- xs, and y <- (y == ye ? ys : y+1).
    - Else x <- x+1.
  - frame_done pulses when the written pixel is (xe, ye); the pointer wraps to (xs, ys) and streaming continues.
- Degenerate windows:
  - xs > xe or ys > ye: only the equality checks above wrap the pointer.
  - Counters are 8-bit and wrap 255 -> 0.
  - No clipping to LCD_W/LCD_H.
- Data bytes in CMD or SKIP produce no output.
- pix_valid and cmd_valid never assert in the same cycle.

Test Plan:
- After rst, send cmd 0x2C then bytes 0xF8, 0x00 -> one cmd_valid with cmd_byte = 0x2C, then pix_valid with pix_x = 0, pix_y = 0, pix_data = 0xF800, 4 clk after the final SCLK rise.
- CASET params 00 05 00 07, RASET params 00 02 00 03, RAMWR, then 6 pixels -> (x, y) sequence (5,2)(6,2)(7,2)(5,3)(6,3)(7,3); frame_done pulses only on the 6th; a 7th pixel lands at (5,2).
- Full-frame RAMWR of 132x162 pixels with incrementing data -> 21384 pix_valid pulses, last at (131,161) with frame_done = 1.
- RAMWR, one high byte, then cmd 0x2A mid-pixel -> no pix_valid; cmd_valid with cmd_byte = 0x2A; subsequent CASET params applied.
- CS_n pulsed high after 3 bits of a byte, then a full byte 0x12, 0x34 in RAMWR -> partial discarded; pix_data = 0x1234.
- RST_n low for 2 SCLK periods during RAMWR -> outputs 0; next RAMWR starts at (0,0) with window 0..131 x 0..161.

Source files
------------

// File: rtl/spi_lcd_rx_if.sv
// Link and decoded-output bundle for the SPI LCD receive decoder.
// The transmitter side (master) drives the five link wires; the decoder (slave) drives the results.
interface spi_lcd_rx_if;
  logic        lcd_clk_in;
  logic        lcd_data_in;
  logic        lcd_dc_in;
  logic        lcd_cs_n_in;
  logic        lcd_rst_n_in;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        pix_valid;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_data;
  logic        frame_done;

  modport master (
    output lcd_clk_in, lcd_data_in, lcd_dc_in, lcd_cs_n_in, lcd_rst_n_in,
    input  cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data, frame_done
  );

  modport slave (
    input  lcd_clk_in, lcd_data_in, lcd_dc_in, lcd_cs_n_in, lcd_rst_n_in,
    output cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data, frame_done
  );
endinterface

// File: rtl/spi_lcd_rx.sv
// Oversampling SPI LCD receiver: rebuilds bytes and decodes CASET/RASET/RAMWR
// into addressed RGB565 pixel writes.
module spi_lcd_rx #(
  parameter int unsigned LCD_W = 132,
  parameter int unsigned LCD_H = 162
) (
  input logic        clk,
  input logic        rst,
  spi_lcd_rx_if.slave lcd
);

  typedef enum logic [2:0] {CMD, CASET_P, RASET_P, RAMWR, SKIP} state_t;

  logic [1:0] clk_sync, dat_sync, dc_sync, cs_sync, rstn_sync;
  logic       ireset;
  logic       sclk_d, rise_q;
  logic [7:0] shreg, rx_byte;
  logic [2:0] bitcnt;
  logic       byte_stb, rx_dc;

  state_t     state;
  logic [1:0] pcnt;
  logic       phase;
  logic [7:0] hi_byte, xs, xe, ys, ye, px, py;
  logic       cmd_valid_q, pix_valid_q, frame_done_q;
  logic [7:0] cmd_byte_q, pix_x_q, pix_y_q;
  logic [15:0] pix_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '0;
      dat_sync  <= '0;
      dc_sync   <= '0;
      cs_sync   <= '1;
      rstn_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[0],  lcd.lcd_clk_in};
      dat_sync  <= {dat_sync[0],  lcd.lcd_data_in};
      dc_sync   <= {dc_sync[0],   lcd.lcd_dc_in};
      cs_sync   <= {cs_sync[0],   lcd.lcd_cs_n_in};
      rstn_sync <= {rstn_sync[0], lcd.lcd_rst_n_in};
    end
  end

  assign ireset = rst | ~rstn_sync[1];

  // sclk_d tracks SCLK even through panel reset so a high SCLK never looks like a fresh rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sclk_d <= clk_sync[1];
      rise_q <= ~ireset & clk_sync[1] & ~sclk_d & ~cs_sync[1];
    end
  end

  always_ff @(posedge clk) begin
    if (ireset) begin
      shreg    <= '0;
      rx_byte  <= '0;
      bitcnt   <= '0;
      rx_dc    <= 1'b0;
      byte_stb <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      if (cs_sync[1]) begin
        bitcnt <= '0;
      end else if (rise_q) begin
        shreg  <= {shreg[6:0], dat_sync[1]};
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          rx_byte  <= {shreg[6:0], dat_sync[1]};
          rx_dc    <= dc_sync[1];
          byte_stb <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ireset) begin
      state        <= CMD;
      pcnt         <= '0;
      phase        <= 1'b0;
      hi_byte      <= '0;
      xs           <= '0;
      ys           <= '0;
      xe           <= 8'(LCD_W - 1);
      ye           <= 8'(LCD_H - 1);
      px           <= '0;
      py           <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cmd_valid_q  <= 1'b0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (byte_stb) begin
        if (!rx_dc) begin
          cmd_valid_q <= 1'b1;
          cmd_byte_q  <= rx_byte;
          pcnt        <= '0;
          phase       <= 1'b0;
          case (rx_byte)
            8'h2A:   state <= CASET_P;
            8'h2B:   state <= RASET_P;
            8'h2C: begin
              state <= RAMWR;
              px    <= xs;
              py    <= ys;
            end
            default: state <= SKIP;
          endcase
        end else begin
          case (state)
            CASET_P, RASET_P: begin
              pcnt <= pcnt + 2'd1;
              if (pcnt == 2'd1) begin
                if (state == CASET_P) xs <= rx_byte;
                else                  ys <= rx_byte;
              end
              if (pcnt == 2'd3) begin
                if (state == CASET_P) xe <= rx_byte;
                else                  ye <= rx_byte;
                state <= SKIP;
              end
            end
            RAMWR: begin
              if (!phase) begin
                hi_byte <= rx_byte;
                phase   <= 1'b1;
              end else begin
                phase        <= 1'b0;
                pix_valid_q  <= 1'b1;
                pix_x_q      <= px;
                pix_y_q      <= py;
                pix_data_q   <= {hi_byte, rx_byte};
                frame_done_q <= (px == xe) && (py == ye);
                // Only equality wraps, so inverted windows simply run through 8-bit rollover
                if (px == xe) begin
                  px <= xs;
                  py <= (py == ye) ? ys : py + 8'd1;
                end else begin
                  px <= px + 8'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign lcd.cmd_valid  = cmd_valid_q;
  assign lcd.cmd_byte   = cmd_byte_q;
  assign lcd.pix_valid  = pix_valid_q;
  assign lcd.pix_x      = pix_x_q;
  assign lcd.pix_y      = pix_y_q;
  assign lcd.pix_data   = pix_data_q;
  assign lcd.frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed bench for spi_lcd_rx: expected command/pixel events are queued as bytes are sent
// and checked against the decoder output, including the pin-to-output latency.
module tb_spi_lcd_rx;
  localparam int unsigned W = 12;
  localparam int unsigned H = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_lcd_rx_if lcd();

  spi_lcd_rx #(.LCD_W(W), .LCD_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .lcd (lcd)
  );

  typedef struct {
    bit          is_cmd;
    logic [7:0]  cb;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] d;
    logic        fd;
  } ev_t;

  ev_t         q[$];
  int          total = 0;
  int          bad = 0;
  int          pix_cnt = 0;
  int unsigned cyc = 0;
  int unsigned last_rise = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (lcd.cmd_valid === 1'b1 || lcd.pix_valid === 1'b1) begin
      ev_t e;
      if (lcd.pix_valid === 1'b1) pix_cnt++;
      chk("valid_exclusive", 32'(lcd.cmd_valid & lcd.pix_valid), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_event", 32'({lcd.cmd_valid, lcd.pix_valid}), 32'd0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - last_rise, 32'd5);
        chk("event_kind", 32'(lcd.cmd_valid), 32'(e.is_cmd));
        if (e.is_cmd) begin
          chk("cmd_byte", 32'(lcd.cmd_byte), 32'(e.cb));
          chk("cmd_frame_done", 32'(lcd.frame_done), 32'd0);
        end else begin
          chk("pix_x", 32'(lcd.pix_x), 32'(e.x));
          chk("pix_y", 32'(lcd.pix_y), 32'(e.y));
          chk("pix_data", 32'(lcd.pix_data), 32'(e.d));
          chk("frame_done", 32'(lcd.frame_done), 32'(e.fd));
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic dc);
    @(negedge clk);
    lcd.lcd_clk_in  = 1'b0;
    lcd.lcd_data_in = b;
    lcd.lcd_dc_in   = dc;
    repeat (3) @(negedge clk);
    lcd.lcd_clk_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      lcd.lcd_clk_in  = 1'b0;
      lcd.lcd_data_in = b[i];
      lcd.lcd_dc_in   = dc;
      repeat (3) @(negedge clk);
      lcd.lcd_clk_in = 1'b1;
      if (i == 0) last_rise = cyc;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    ev_t e;
    e = '{is_cmd: 1'b1, cb: b, x: 8'd0, y: 8'd0, d: 16'd0, fd: 1'b0};
    q.push_back(e);
    send_byte(b, 1'b0);
  endtask

  task automatic send_pix(input logic [15:0] d, input logic [7:0] x, input logic [7:0] y, input logic fd);
    ev_t e;
    e = '{is_cmd: 1'b0, cb: 8'd0, x: x, y: y, d: d, fd: fd};
    send_byte(d[15:8], 1'b1);
    q.push_back(e);
    send_byte(d[7:0], 1'b1);
  endtask

  task automatic send_params(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
    send_byte(d, 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst              = 1'b1;
    lcd.lcd_clk_in   = 1'b0;
    lcd.lcd_data_in  = 1'b0;
    lcd.lcd_dc_in    = 1'b0;
    lcd.lcd_cs_n_in  = 1'b0;
    lcd.lcd_rst_n_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_outputs",
        32'({lcd.cmd_valid, lcd.pix_valid, lcd.frame_done, lcd.cmd_byte, lcd.pix_x, lcd.pix_y} | 32'(lcd.pix_data)),
        32'd0);

    // Data byte while idle in CMD: must be silent
    send_byte(8'h55, 1'b1);

    // First pixel at origin after reset
    send_cmd(8'h2C);
    send_pix(16'hF800, 8'd0, 8'd0, 1'b0);
    drain("drain_first_pixel");

    // Small window, wrap and frame_done on the last pixel
    send_cmd(8'h2A);
    send_params(8'h00, 8'h05, 8'h00, 8'h07);
    send_cmd(8'h2B);
    send_params(8'h00, 8'h02, 8'h00, 8'h03);
    send_cmd(8'h2C);
    for (int k = 0; k < 7; k++)
      send_pix(16'h1000 + 16'(k), 8'(5 + k % 3), 8'(2 + (k / 3) % 2), k == 5);
    drain("drain_window");

    // Command arriving mid-pixel abandons the half pixel
    send_cmd(8'h2C);
    send_byte(8'hAA, 1'b1);
    send_cmd(8'h2A);
    send_params(8'h00, 8'h01, 8'h00, 8'h02);
    send_cmd(8'h2C);
    send_pix(16'h0101, 8'd1, 8'd2, 1'b0);
    send_pix(16'h0202, 8'd2, 8'd2, 1'b0);
    send_pix(16'h0303, 8'd1, 8'd3, 1'b0);
    drain("drain_abort");

    // Chip-select glitch after 3 bits discards the partial byte
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    lcd.lcd_cs_n_in = 1'b1;
    repeat (6) @(negedge clk);
    lcd.lcd_cs_n_in = 1'b0;
    repeat (4) @(negedge clk);
    send_pix(16'h1234, 8'd2, 8'd3, 1'b1);
    drain("drain_cs");

    // Panel reset mid-pixel: outputs clear, window returns to full panel
    send_cmd(8'h2C);
    send_byte(8'h77, 1'b1);
    lcd.lcd_rst_n_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstn_outputs",
        32'({lcd.cmd_valid, lcd.pix_valid, lcd.frame_done, lcd.cmd_byte, lcd.pix_x, lcd.pix_y} | 32'(lcd.pix_data)),
        32'd0);
    repeat (6) @(negedge clk);
    lcd.lcd_rst_n_in = 1'b1;
    repeat (4) @(negedge clk);
    drain("drain_rstn");

    // Full frame on the reset window, then one more pixel wraps to origin
    base = pix_cnt;
    send_cmd(8'h2C);
    for (int i = 0; i < int'(W * H); i++)
      send_pix(16'(i), 8'(i % int'(W)), 8'(i / int'(W)), i == int'(W * H) - 1);
    send_pix(16'hBEEF, 8'd0, 8'd0, 1'b0);
    drain("drain_frame");
    chk("frame_pixel_count", 32'(pix_cnt - base), 32'(W * H + 1));

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
